// File: rtl/rvfi_cmp_pkg.sv
// Shared types for the RVFI retirement comparator: the retirement record, mask bit
// positions, FSM states and the field-by-field compare. Mem fields count only with RVFI_CMP_MEM_EN.
package rvfi_cmp_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [4:0]      rd1_addr;
    logic [XLEN-1:0] rd1_wdata;
    logic            trap;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wmask;
  } rvfi_cmp_entry_t;

  localparam int MASK_W         = 8;
  localparam int MASK_ORDER     = 0;
  localparam int MASK_INSN      = 1;
  localparam int MASK_PC_RDATA  = 2;
  localparam int MASK_PC_WDATA  = 3;
  localparam int MASK_RD1_ADDR  = 4;
  localparam int MASK_RD1_WDATA = 5;
  localparam int MASK_TRAP      = 6;
  localparam int MASK_MEM       = 7;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } cmp_state_e;

  function automatic logic [MASK_W-1:0] entry_mismatch(input rvfi_cmp_entry_t a,
                                                       input rvfi_cmp_entry_t b);
    logic [MASK_W-1:0] m;
    m                 = '0;
    m[MASK_ORDER]     = (a.order    != b.order);
    m[MASK_INSN]      = (a.insn     != b.insn);
    m[MASK_PC_RDATA]  = (a.pc_rdata != b.pc_rdata);
    m[MASK_PC_WDATA]  = (a.pc_wdata != b.pc_wdata);
    m[MASK_RD1_ADDR]  = (a.rd1_addr != b.rd1_addr);
    // x0 writes carry no architectural value, so their data is not compared.
    m[MASK_RD1_WDATA] = ((a.rd1_addr != 5'd0) || (b.rd1_addr != 5'd0)) &&
                        (a.rd1_wdata != b.rd1_wdata);
    m[MASK_TRAP]      = (a.trap     != b.trap);
`ifdef RVFI_CMP_MEM_EN
    m[MASK_MEM]       = (a.mem_addr  != b.mem_addr)  ||
                        (a.mem_wdata != b.mem_wdata) ||
                        (a.mem_wmask != b.mem_wmask);
`else
    m[MASK_MEM]       = 1'b0;
`endif
    return m;
  endfunction

endpackage

// File: rtl/rvfi_comparator_if.sv
// Retirement stream bundle: one valid strobe plus the retirement record.
// The producer drives through master; a FIFO push port consumes through slave.
interface rvfi_comparator_if;
  import rvfi_cmp_pkg::*;

  logic            valid;
  rvfi_cmp_entry_t entry;

  modport master (output valid, output entry);
  modport slave  (input  valid, input  entry);

endinterface

// File: rtl/rvfi_cmp_fifo.sv
// Retirement FIFO with an extra pointer bit separating full from empty.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module rvfi_cmp_fifo
  import rvfi_cmp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  rvfi_comparator_if.slave        push_if,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    drop_o,
  output rvfi_cmp_entry_t         head_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]     wptr_q, wptr_d;
  logic [AW:0]     rptr_q, rptr_d;
  logic            do_push, do_pop;
  rvfi_cmp_entry_t mem_q [DEPTH];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_if.valid && !flush_i && (!full_o || do_pop);
  assign drop_o  = push_if.valid && !flush_i && !do_push;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which slots hold live entries.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_if.entry;
  end

endmodule

// File: rtl/rvfi_comparator.sv
// Lock-step RVFI checker: buffers DUT and reference retirements, compares heads pairwise
// and halts on mismatch or overflow. Define RVFI_CMP_MEM_EN to include mem fields in bit 7.
module rvfi_comparator
  import rvfi_cmp_pkg::*;
#(
  parameter int DEPTH            = 4,
  parameter int STOP_ON_MISMATCH = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dut_valid_i,
  input  rvfi_cmp_entry_t   dut_entry_i,
  input  logic              ref_valid_i,
  input  rvfi_cmp_entry_t   ref_entry_i,
  input  logic              clear_i,
  output logic              cmp_valid_o,
  output logic              mismatch_o,
  output logic [MASK_W-1:0] mismatch_mask_o,
  output logic              err_sticky_o,
  output logic              overflow_o,
  output logic              halted_o,
  output logic [31:0]       cmp_count_o
);

  cmp_state_e        state_q, state_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       count_q, count_d;

  logic              dut_empty, dut_full, dut_drop;
  logic              ref_empty, ref_full, ref_drop;
  rvfi_cmp_entry_t   dut_head, ref_head;
  logic              do_cmp, ovf_evt;
  logic [MASK_W-1:0] mask_now;

  rvfi_comparator_if dut_push_if ();
  rvfi_comparator_if ref_push_if ();

  // Clear wins over everything, so pushes are suppressed while it is high.
  assign dut_push_if.valid = dut_valid_i && !clear_i;
  assign dut_push_if.entry = dut_entry_i;
  assign ref_push_if.valid = ref_valid_i && !clear_i;
  assign ref_push_if.entry = ref_entry_i;

  assign do_cmp   = (state_q == ST_RUN) && !dut_empty && !ref_empty && !clear_i;
  assign mask_now = entry_mismatch(dut_head, ref_head);
  // Drops while halted are expected backpressure, not overflow.
  assign ovf_evt  = (state_q == ST_RUN) && (dut_drop || ref_drop);

  rvfi_cmp_fifo #(.DEPTH(DEPTH)) u_dut_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_if (dut_push_if),
    .pop_i   (do_cmp),
    .flush_i (clear_i),
    .empty_o (dut_empty),
    .full_o  (dut_full),
    .drop_o  (dut_drop),
    .head_o  (dut_head)
  );

  rvfi_cmp_fifo #(.DEPTH(DEPTH)) u_ref_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_if (ref_push_if),
    .pop_i   (do_cmp),
    .flush_i (clear_i),
    .empty_o (ref_empty),
    .full_o  (ref_full),
    .drop_o  (ref_drop),
    .head_o  (ref_head)
  );

  always_comb begin
    state_d     = state_q;
    cmp_valid_d = do_cmp;
    mask_d      = do_cmp ? mask_now : '0;
    err_d       = err_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    if (clear_i) begin
      state_d = ST_RUN;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (do_cmp && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
      if (do_cmp && (mask_now != '0)) begin
        err_d = 1'b1;
        if (STOP_ON_MISMATCH != 0) state_d = ST_HALT;
      end
      if (ovf_evt) begin
        ovf_d   = 1'b1;
        err_d   = 1'b1;
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      cmp_valid_q <= 1'b0;
      mask_q      <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmp_valid_q <= cmp_valid_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
    end
  end

  assign cmp_valid_o     = cmp_valid_q;
  assign mismatch_mask_o = mask_q;
  assign mismatch_o      = |mask_q;
  assign err_sticky_o    = err_q;
  assign overflow_o      = ovf_q;
  assign halted_o        = (state_q == ST_HALT);
  assign cmp_count_o     = count_q;

endmodule

// File: doc/rvfi_comparator.md
RVFI_COMPARATOR -- requirements
Module: rvfi_comparator

Interface
REQ-001 Parameter DEPTH, default 4, entries per input FIFO; power of two, minimum 2.
REQ-002 Parameter STOP_ON_MISMATCH, default 1; when 1, the first error halts comparison.
REQ-003 Ports SHALL be as follows; clock and reset: one clock, reset asynchronous and active-low.
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
dut_valid_i  in  1  DUT retirement valid.
dut_entry_i  in  $bits(rvfi_cmp_entry_t)  DUT retirement record.
ref_valid_i  in  1  reference-model retirement valid.
ref_entry_i  in  $bits(rvfi_cmp_entry_t)  reference retirement record.
clear_i  in  1  flush both FIFOs, clear sticky flags, return to RUN.
cmp_valid_o  out  1  one-cycle pulse: a pair was compared.
mismatch_o  out  1  one-cycle pulse, qualified by cmp_valid_o.
mismatch_mask_o  out  8  per-field mismatch bits for the pair compared.
err_sticky_o  out  1  set on any mismatch or overflow.
overflow_o  out  1  sticky FIFO overflow.
halted_o  out  1  FSM is in HALT.
cmp_count_o  out  32  number of pairs compared, saturating.

Function
REQ-004 Each valid input SHALL be pushed into its own FIFO in the same cycle it is asserted; both inputs may be valid in one cycle.
REQ-005 In RUN, when both FIFO heads are present, both SHALL be popped and compared; results register one cycle later.
REQ-006 Mask bits, in this order: order, insn, pc_rdata, pc_wdata, rd1_addr, rd1_wdata, trap, mem (mem_addr/mem_wdata/mem_wmask).
REQ-007 rd1_wdata SHALL be compared only when rd1_addr is nonzero; otherwise its mask bit is 0.
REQ-008 mismatch_o is the OR of mismatch_mask_o, valid with cmp_valid_o; the mask is zero when cmp_valid_o is low.
REQ-009 cmp_count_o SHALL increment per comparison and saturate at 32'hFFFF_FFFF.
REQ-010 Full FIFO: a push with a simultaneous pop SHALL succeed.
REQ-011 Full FIFO: a push without a pop SHALL drop the entry and set overflow_o and err_sticky_o.
REQ-012 Overflow SHALL force HALT regardless of STOP_ON_MISMATCH.
REQ-013 Pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-014 FSM states RUN and HALT; RUN->HALT on a mismatch (STOP_ON_MISMATCH=1) or on overflow; HALT->RUN only on clear_i.
REQ-015 In HALT there are no pops and no comparisons; pushes continue until full, and further pushes are dropped without setting overflow.
REQ-016 clear_i has priority over same-cycle push, pop, and compare: FIFOs are emptied, sticky flags cleared, cmp_count_o kept.

Reset
REQ-017 On rst_ni low, asynchronously: FIFOs empty, state RUN, all outputs 0, cmp_count_o 0.
REQ-018 Reset mid-comparison SHALL discard any in-flight result; no cmp_valid_o pulse follows reset release.

Configuration
REQ-019 Macro RVFI_CMP_MEM_EN defined: mem fields are compared and feed mask bit 7.
REQ-020 Macro RVFI_CMP_MEM_EN undefined: mem fields are ignored and mask bit 7 is tied to 0.

Structure
REQ-021 Package rvfi_cmp_pkg SHALL hold rvfi_cmp_entry_t (XLEN=32; order 64, insn 32, pc_rdata/pc_wdata 32, rd1_addr 5, rd1_wdata 32, trap 1, mem_addr 32, mem_wdata 32, mem_wmask 4), the mask bit index constants, and the FSM state enum.
REQ-022 One sub-module, rvfi_cmp_fifo, is instantiated twice, once for DUT and once for reference.

Verification
REQ-023 Ten identical retirements, DUT leading by 2 cycles -> ten cmp_valid_o pulses, mismatch_o never set, cmp_count_o=10.
REQ-024 Third REF pair has rd1_wdata=0x5 vs 0x6 with rd1_addr=3 -> mask 8'h20, mismatch_o pulse, err_sticky_o=1, halted_o=1, cmp_count_o=3.
REQ-025 rd1_addr=0 with differing rd1_wdata -> no mismatch.
REQ-026 DEPTH=4, DUT pushes 5 with no REF -> overflow_o=1, halted_o=1; then clear_i -> all flags 0, FIFOs empty.
REQ-027 mem_wdata differs, with RVFI_CMP_MEM_EN defined -> mask 8'h80; without the macro -> no mismatch.
REQ-028 rst_ni asserted with both heads present -> outputs 0 immediately; no cmp_valid_o after release.
